// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus per-bit stability counter for the slide-switch bus.
// Define SW_DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0]       glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]            s1;
  logic [WIDTH-1:0]            s2;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0]            clean_nxt;
  logic [WIDTH-1:0]            rise_nxt;
  logic [WIDTH-1:0]            fall_nxt;
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  logic                        abort_any;
`endif

  // A bit is accepted only after s2 has disagreed with sw_clean for STABLE_CYCLES edges in a row.
  always_comb begin
    cnt_nxt   = '0;
    clean_nxt = sw_clean;
    rise_nxt  = '0;
    fall_nxt  = '0;
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    abort_any = 1'b0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      if (s2[i] != sw_clean[i]) begin
        if (cnt[i] == CNT_MAX) begin
          clean_nxt[i] = s2[i];
          rise_nxt[i]  = s2[i];
          fall_nxt[i]  = ~s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
      else if (cnt[i] != '0) begin
        abort_any = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      cnt        <= '0;
      sw_clean   <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
    end else begin
      s1         <= sw_raw;
      s2         <= s1;
      cnt        <= cnt_nxt;
      sw_clean   <= clean_nxt;
      sw_rise    <= rise_nxt;
      sw_fall    <= fall_nxt;
      sw_changed <= |(rise_nxt | fall_nxt);
    end
  end

`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  // Saturates so a long burst of bounces cannot wrap back to a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= 8'd0;
    end else if (abort_any && glitch_cnt != 8'hFF) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed scenarios plus random switch activity,
// compared every cycle against a sliding-window reference model.
module tb_sw_debounce;

  localparam int WIDTH  = 8;
  localparam int STABLE = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0]       glitch_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: raw delayed two samples, and a window of the last STABLE synchronized samples.
  logic [WIDTH-1:0] m1, m2, mClean, mRise, mFall;
  logic             mChanged;
  int               mGlitch;
  logic [WIDTH-1:0] win [STABLE];
  int               risePulses [WIDTH];
  int               fallPulses [WIDTH];

  always #5 clk = ~clk;

  sw_debounce #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  function automatic void modelReset();
    m1 = '0; m2 = '0; mClean = '0; mRise = '0; mFall = '0; mChanged = 1'b0; mGlitch = 0;
    for (int k = 0; k < STABLE; k++) win[k] = '0;
  endfunction

  // A bit flips when every sample in the window disagrees with the accepted level.
  function automatic void modelEdge();
    logic [WIDTH-1:0] acc;
    logic             abort;
    logic             allDiff;
    for (int k = STABLE - 1; k > 0; k--) win[k] = win[k-1];
    win[0] = m2;
    acc   = '0;
    abort = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      allDiff = 1'b1;
      for (int k = 0; k < STABLE; k++) if (win[k][i] == mClean[i]) allDiff = 1'b0;
      acc[i] = allDiff;
      if (win[1][i] != mClean[i] && win[0][i] == mClean[i]) abort = 1'b1;
    end
    mRise    = acc & ~mClean;
    mFall    = acc & mClean;
    mClean   = mClean ^ acc;
    mChanged = |acc;
    if (abort && mGlitch < 255) mGlitch++;
    m2 = m1;
    m1 = sw_raw;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, ".sw_clean"},   32'(sw_clean),   32'(mClean));
    checkEq({tag, ".sw_rise"},    32'(sw_rise),    32'(mRise));
    checkEq({tag, ".sw_fall"},    32'(sw_fall),    32'(mFall));
    checkEq({tag, ".sw_changed"}, 32'(sw_changed), 32'(mChanged));
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    checkEq({tag, ".glitch_cnt"}, 32'(glitch_cnt), 32'(mGlitch));
`endif
    for (int i = 0; i < WIDTH; i++) begin
      if (sw_rise[i] === 1'b1) risePulses[i]++;
      if (sw_fall[i] === 1'b1) fallPulses[i]++;
    end
  endtask

  task automatic clearPulses();
    for (int i = 0; i < WIDTH; i++) begin
      risePulses[i] = 0;
      fallPulses[i] = 0;
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] raw, input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      sw_raw = raw;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
    end
  endtask

  task automatic doReset(input logic [WIDTH-1:0] raw, input int cycles);
    sw_raw = raw;
    rst_n  = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_async");
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold");
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] cur;
    rst_n  = 1'b1;
    sw_raw = '0;
    clearPulses();
    modelReset();
    #2;

    // Reset with all switches high, then release and let them be accepted.
    doReset(8'hFF, 3);
    clearPulses();
    applyStimulus(8'hFF, 10, "reset_release");
    checkEq("reset_release.final_clean", 32'(sw_clean), 32'hFF);
    checkEq("reset_release.rise_bit0", 32'(risePulses[0]), 32'd1);

    // Clean single-bit change: update lands on the sixth edge counted from E0.
    applyStimulus(8'h00, 10, "to_zero");
    clearPulses();
    applyStimulus(8'h08, 5, "single_wait");
    checkEq("single.before_accept", 32'(sw_clean), 32'h00);
    applyStimulus(8'h08, 1, "single_accept");
    checkEq("single.clean", 32'(sw_clean), 32'h08);
    checkEq("single.rise",  32'(sw_rise),  32'h08);
    applyStimulus(8'h08, 1, "single_after");
    checkEq("single.rise_width", 32'(sw_rise), 32'h00);
    checkEq("single.fall_count", 32'(fallPulses[3]), 32'd0);

    // Bounce on bit 0 before settling high.
    applyStimulus(8'h00, 10, "to_zero");
    clearPulses();
    applyStimulus(8'h01, 2, "bounce_hi");
    applyStimulus(8'h00, 2, "bounce_lo");
    applyStimulus(8'h01, 5, "bounce_settle");
    checkEq("bounce.no_early_update", 32'(sw_clean), 32'h00);
    applyStimulus(8'h01, 5, "bounce_settle");
    checkEq("bounce.clean", 32'(sw_clean), 32'h01);
    checkEq("bounce.rise_count", 32'(risePulses[0]), 32'd1);
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    checkEq("bounce.glitch_cnt", 32'(glitch_cnt), 32'd1);
`endif

    // Simultaneous rise and fall across the nibbles.
    applyStimulus(8'h0F, 10, "to_0f");
    applyStimulus(8'hF0, 5, "simul_wait");
    checkEq("simul.before_accept", 32'(sw_clean), 32'h0F);
    applyStimulus(8'hF0, 1, "simul_accept");
    checkEq("simul.clean",   32'(sw_clean),   32'hF0);
    checkEq("simul.rise",    32'(sw_rise),    32'hF0);
    checkEq("simul.fall",    32'(sw_fall),    32'h0F);
    checkEq("simul.changed", 32'(sw_changed), 32'd1);
    applyStimulus(8'hF0, 1, "simul_after");
    checkEq("simul.changed_width", 32'(sw_changed), 32'd0);

    // Reset in the middle of a count on bit 7.
    applyStimulus(8'h00, 10, "to_zero");
    clearPulses();
    applyStimulus(8'h80, 3, "midreset_count");
    doReset(8'h80, 1);
    applyStimulus(8'h80, 4, "midreset_release");
    checkEq("midreset.no_early_update", 32'(sw_clean), 32'h00);
    applyStimulus(8'h80, 6, "midreset_release");
    checkEq("midreset.clean", 32'(sw_clean), 32'h80);
    checkEq("midreset.rise_count", 32'(risePulses[7]), 32'd1);

    // Repeated single-cycle glitches on bit 1 must never be accepted.
    applyStimulus(8'h00, 10, "to_zero");
    clearPulses();
    for (int g = 0; g < 300; g++) begin
      applyStimulus(8'h02, 1, "glitch_hi");
      applyStimulus(8'h00, 3, "glitch_lo");
    end
    checkEq("glitch.clean_bit1", 32'(sw_clean[1]), 32'd0);
    checkEq("glitch.rise_count", 32'(risePulses[1]), 32'd0);
    checkEq("glitch.fall_count", 32'(fallPulses[1]), 32'd0);
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    checkEq("glitch.saturated", 32'(glitch_cnt), 32'd255);
`endif

    // Random switch activity with varied dwell times and occasional resets.
    cur = 8'h00;
    for (int s = 0; s < 150; s++) begin
      cur = cur ^ WIDTH'($urandom & $urandom);
      if ($urandom_range(0, 29) == 0) doReset(cur, $urandom_range(1, 3));
      applyStimulus(cur, $urandom_range(1, 9), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
